// File: rtl/demux1_2_reg_pkg.sv
// Shared constants for the registered 1-to-2 steering stage.
package demux1_2_reg_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 16;

    localparam logic SEL_CH0 = 1'b0;
    localparam logic SEL_CH1 = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/out_slot_reg.sv
// One-entry output slot: holding register, valid flag, saturating delivery
// counter and the ready term the steering logic uses for in_ready.
//
// state      | meaning
// -----------+------------------------------------------------------
// SLOT_EMPTY | nothing held, slot can always take a word
// SLOT_FULL  | word held on data, waits for the consumer's ready
module out_slot_reg
    import demux1_2_reg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt,
    output logic             slot_ready
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    slot_state_e state, state_nxt;
    logic        deliver;

    assign valid      = (state == SLOT_FULL);
    assign deliver    = valid && ready;
    // A full slot can still take a word in the same cycle it is drained.
    assign slot_ready = !valid || ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a load always leaves the slot full, a drain without load empties it.
    always_comb begin
        state_nxt = state;
        case (state)
            SLOT_EMPTY: if (load) state_nxt = SLOT_FULL;
            SLOT_FULL:  if (ready && !load) state_nxt = SLOT_EMPTY;
            default:    state_nxt = SLOT_EMPTY;
        endcase
    end

    // Data register only changes on load, so it keeps the last word while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

    // Delivery counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (deliver && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/demux1_2_reg.sv
// Registered 1-to-2 steering stage: routes one valid/ready source word to
// channel 0 or channel 1 according to in_sel, one-entry slot per channel.
module demux1_2_reg
    import demux1_2_reg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic slot0_ready;
    logic slot1_ready;
    logic accept;
    logic load0;
    logic load1;

    // Only the selected slot can stall the source; gated low while in reset.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            in_ready = (in_sel == SEL_CH1) ? slot1_ready : slot0_ready;
        end
    end

    assign accept = in_valid && in_ready;
    assign load0  = accept && (in_sel == SEL_CH0);
    assign load1  = accept && (in_sel == SEL_CH1);

    out_slot_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load0),
        .load_data  (in_data),
        .ready      (out0_ready),
        .valid      (out0_valid),
        .data       (out0_data),
        .cnt        (cnt0),
        .slot_ready (slot0_ready)
    );

    out_slot_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load1),
        .load_data  (in_data),
        .ready      (out1_ready),
        .valid      (out1_valid),
        .data       (out1_data),
        .cnt        (cnt1),
        .slot_ready (slot1_ready)
    );

endmodule

// File: tb/tb_demux1_2_reg.sv
// Self-checking bench for demux1_2_reg: directed scenarios plus a randomized
// run against a queue-based reference model. A second instance with 4-bit
// counters shares the stimulus to exercise saturation.
module tb_demux1_2_reg;

    localparam int W  = 32;
    localparam int CW = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_sel;
    logic [W-1:0]  in_data;
    logic          out0_ready;
    logic          out1_ready;

    logic          in_ready,   s_in_ready;
    logic          out0_valid, s_out0_valid;
    logic          out1_valid, s_out1_valid;
    logic [W-1:0]  out0_data,  s_out0_data;
    logic [W-1:0]  out1_data,  s_out1_data;
    logic [CW-1:0] cnt0, cnt1;
    logic [SW-1:0] s_cnt0, s_cnt1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux1_2_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    demux1_2_reg #(.WIDTH(W), .CNT_W(SW)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_sel(in_sel), .in_data(in_data),
        .out0_valid(s_out0_valid), .out0_ready(out0_ready), .out0_data(s_out0_data),
        .out1_valid(s_out1_valid), .out1_ready(out1_ready), .out1_data(s_out1_data),
        .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD_BEEF;
        out0_ready = 1'b1; out1_ready = 1'b1;
        tick(); tick();
        checks++; if (out0_valid !== 1'b0) begin failures++; $display("FAIL rst_out0_valid got=%b exp=0", out0_valid); end
        checks++; if (out1_valid !== 1'b0) begin failures++; $display("FAIL rst_out1_valid got=%b exp=0", out1_valid); end
        checks++; if (cnt0 !== '0 || cnt1 !== '0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", cnt0, cnt1); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (out0_data !== '0 || out1_data !== '0) begin failures++; $display("FAIL rst_data got=%h/%h exp=0/0", out0_data, out1_data); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out0_valid !== 1'b1 || out0_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL first_word got=%b/%h exp=1/deadbeef", out0_valid, out0_data); end
        checks++; if (out1_valid !== 1'b0) begin failures++; $display("FAIL first_word_ch1 got=%b exp=0", out1_valid); end
        tick();
        checks++; if (cnt0 !== 16'd1 || out0_valid !== 1'b0) begin failures++; $display("FAIL first_deliver got cnt0=%0d valid=%b exp=1/0", cnt0, out0_valid); end
    endtask

    task automatic test_alternating();
        apply_reset();
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sel = i[0]; in_data = W'(i + 1);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL alt_stall word=%0d in_ready=%b exp=1", i + 1, in_ready); end
            tick();
            if (i[0]) begin
                checks++; if (out1_valid !== 1'b1 || out1_data !== W'(i + 1)) begin failures++; $display("FAIL alt_ch1 got=%b/%h exp=1/%h", out1_valid, out1_data, i + 1); end
            end else begin
                checks++; if (out0_valid !== 1'b1 || out0_data !== W'(i + 1)) begin failures++; $display("FAIL alt_ch0 got=%b/%h exp=1/%h", out0_valid, out0_data, i + 1); end
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (cnt0 !== 16'd2 || cnt1 !== 16'd2) begin failures++; $display("FAIL alt_cnt got=%0d/%0d exp=2/2", cnt0, cnt1); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out0_ready = 1'b0; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        tick();
        checks++; if (out0_data !== 32'hA || out0_valid !== 1'b1) begin failures++; $display("FAIL bp_hold got=%b/%h exp=1/a", out0_valid, out0_data); end
        checks++; if (cnt0 !== 16'd0) begin failures++; $display("FAIL bp_cnt_stalled got=%0d exp=0", cnt0); end
        out0_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0; out0_ready = 1'b0;
        checks++; if (out0_data !== 32'hB || out0_valid !== 1'b1 || cnt0 !== 16'd1) begin failures++; $display("FAIL bp_swap got=%b/%h cnt0=%0d exp=1/b/1", out0_valid, out0_data, cnt0); end
    endtask

    task automatic test_independence();
        out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hC;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ind_in_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out1_valid !== 1'b1 || out1_data !== 32'hC) begin failures++; $display("FAIL ind_ch1 got=%b/%h exp=1/c", out1_valid, out1_data); end
        checks++; if (out0_valid !== 1'b1 || out0_data !== 32'hB || cnt0 !== 16'd1) begin failures++; $display("FAIL ind_ch0 got=%b/%h cnt0=%0d exp=1/b/1", out0_valid, out0_data, cnt0); end
    endtask

    task automatic test_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b/%b exp=0/0", out0_valid, out1_valid); end
        checks++; if (out0_data !== '0 || out1_data !== '0) begin failures++; $display("FAIL mid_data got=%h/%h exp=0/0", out0_data, out1_data); end
        checks++; if (cnt0 !== '0 || cnt1 !== '0) begin failures++; $display("FAIL mid_cnt got=%0d/%0d exp=0/0", cnt0, cnt1); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        apply_reset();
        out1_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_sel = 1'b1; in_data = W'(32'h100 + i);
            tick();
            if (i == 14) begin
                checks++; if (s_cnt1 !== 4'd14) begin failures++; $display("FAIL sat_pre got=%0d exp=14", s_cnt1); end
            end
        end
        in_valid = 1'b0;
        tick(); tick();
        checks++; if (s_cnt1 !== 4'hF) begin failures++; $display("FAIL sat_cnt1 got=%0d exp=15", s_cnt1); end
        checks++; if (cnt1 !== 16'd20) begin failures++; $display("FAIL sat_wide_cnt1 got=%0d exp=20", cnt1); end
    endtask

    task automatic test_random();
        logic [W-1:0] q[2][$];
        logic [W-1:0] last[2];
        int           delivered[2];
        logic         rdy[2];
        logic         exp_ready;
        logic         held;
        apply_reset();
        last[0] = '0; last[1] = '0;
        delivered[0] = 0; delivered[1] = 0;
        held = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!held) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 1'($urandom_range(0, 1));
                in_data  = $urandom();
            end
            out0_ready = ($urandom_range(0, 9) < 6);
            out1_ready = ($urandom_range(0, 9) < 6);
            rdy[0] = out0_ready; rdy[1] = out1_ready;
            exp_ready = (q[in_sel].size() == 0) || rdy[in_sel];
            #1;
            checks++; if (in_ready !== exp_ready) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready); end
            checks++; if (out0_valid !== (q[0].size() != 0) || out0_data !== last[0]) begin failures++; $display("FAIL rnd_ch0 cyc=%0d got=%b/%h exp=%b/%h", cyc, out0_valid, out0_data, q[0].size() != 0, last[0]); end
            checks++; if (out1_valid !== (q[1].size() != 0) || out1_data !== last[1]) begin failures++; $display("FAIL rnd_ch1 cyc=%0d got=%b/%h exp=%b/%h", cyc, out1_valid, out1_data, q[1].size() != 0, last[1]); end
            checks++; if (cnt0 !== CW'(delivered[0]) || cnt1 !== CW'(delivered[1])) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, cnt0, cnt1, delivered[0], delivered[1]); end
            checks++; if (s_cnt0 !== SW'(delivered[0] > 15 ? 15 : delivered[0]) || s_cnt1 !== SW'(delivered[1] > 15 ? 15 : delivered[1])) begin failures++; $display("FAIL rnd_sat_cnt cyc=%0d got=%0d/%0d", cyc, s_cnt0, s_cnt1); end
            for (int c = 0; c < 2; c++) begin
                if (q[c].size() != 0 && rdy[c]) begin
                    void'(q[c].pop_front());
                    delivered[c]++;
                end
            end
            if (in_valid && exp_ready) begin
                q[in_sel].push_back(in_data);
                last[in_sel] = in_data;
            end
            held = in_valid && !exp_ready;
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alternating();
        test_backpressure();
        test_independence();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux1_2_reg.md
Name: demux1_2_reg

Overview:
- Registered 1-to-2 steering stage, the inverse of the 32-bit 2:1 select mux used throughout the datapath.
- Takes one valid/ready source word plus a select bit and delivers it to one of two destination channels (e.g. ALU result to writeback vs. branch/target path).
- Each destination has a one-entry output register with a valid/ready handshake and a saturating delivery counter.
- Sits between the execute stage and the downstream consumers.

Parameters:
WIDTH, 32, data word width
CNT_W, 16, width of each per-channel delivery counter

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  source word present
in_ready  output  1  block accepts source word this cycle
in_sel  input  1  0 = route to channel 0, 1 = route to channel 1
in_data  input  WIDTH  source word
out0_valid  output  1  channel 0 holds a word
out0_ready  input  1  channel 0 consumer takes the word
out0_data  output  WIDTH  channel 0 word
out1_valid  output  1  channel 1 holds a word
out1_ready  input  1  channel 1 consumer takes the word
out1_data  output  WIDTH  channel 1 word
cnt0  output  CNT_W  words delivered on channel 0
cnt1  output  CNT_W  words delivered on channel 1

Behaviour:
- Reset (rst_n low, asynchronous): out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, cnt0=0, cnt1=0. Any held word is discarded. in_ready reads 0 while rst_n is low. Deassertion is sampled synchronously; the block is operational on the first clk edge with rst_n high.
- Per-channel slot state. There is no other FSM.
  - EMPTY (outN_valid=0) -> FULL on accept with in_sel=N.
  - FULL -> EMPTY on outN_ready=1 with no new accept for N.
  - FULL -> FULL with new data when outN_ready=1 and a new accept for N occur in the same cycle.
- in_ready is combinational:
  - in_sel=0: in_ready = !out0_valid || out0_ready.
  - in_sel=1: in_ready = !out1_valid || out1_ready.
- Accept = in_valid && in_ready. On accept, in_data is registered into the selected slot; outN_valid rises on the next edge. Latency is 1 cycle; throughput is 1 word/cycle per channel with a continuously ready consumer.
- Source rule: once in_valid=1 and not accepted, in_data and in_sel are held stable until accept. The block does not check this.
- Consumer rule: outN_valid and outN_data stay stable until outN_ready=1.
- The unselected channel is unaffected by an accept. Channel 0 may drain while channel 1 loads in the same cycle.
- A stalled channel blocks only source words that select it (head-of-line). Words for the other channel are not reordered past a stalled head, because the source presents one word at a time.
- Counters:
  - cntN increments when outN_valid && outN_ready.
  - cntN saturates at 2^CNT_W-1 and does not wrap.
- out data registers load only on accept. When outN_valid=0, data holds its last value (0 after reset).
- If reset asserts mid-transfer, the held words are lost with no partial delivery.

Decomposition:
- Shared package: WIDTH default constant, CNT_W default constant, channel select encoding constants SEL_CH0=1'b0 and SEL_CH1=1'b1.
- One sub-module, out_slot_reg, instantiated twice. It contains the one-entry register, the valid flag, the saturating counter and the slot-ready term. The top level holds the select steering and in_ready.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out0_valid=out1_valid=0, cnt0=cnt1=0, in_ready=0. Release, then send 32'hDEADBEEF with sel=0 -> out0_valid=1 one cycle later with out0_data=32'hDEADBEEF.
- Alternating stream, both ready=1: send 32'h1, 32'h2, 32'h3, 32'h4 with sel=0, 1, 0, 1 on consecutive cycles -> each word appears 1 cycle later on the correct channel, no stall cycles, cnt0=2, cnt1=2.
- Backpressure: out0_ready=0, send 32'hA (sel 0) then 32'hB (sel 0) -> in_ready=0 while 32'hB waits, out0_data stays 32'hA. Raise out0_ready for 1 cycle -> 32'hA delivered, 32'hB loaded the same edge, cnt0=1.
- Independence: out0_ready=0 with slot 0 full, send 32'hC with sel=1 -> accepted immediately, out1_data=32'hC, slot 0 unchanged.
- Reset mid-operation: both slots full, pulse rst_n low between edges -> valids drop immediately and asynchronously, data=0, counters=0.
- Saturation with CNT_W=4: deliver 20 words on channel 1 -> cnt1 stops at 4'hF.
